// File: rtl/amp_safety_check_pkg.sv
// Shared widths, constants and per-channel latch states for the amplifier current monitor.
package safety_pkg;

  localparam int unsigned NUM_CHAN   = 4;
  localparam int unsigned CUR_W      = 16;
  localparam int unsigned CNT_W      = 8;

  // Offset-binary encoding: this code is 0 A on both feedback and command.
  localparam logic [CUR_W-1:0] CUR_ZERO = 16'h8000;

  typedef enum logic {
    ARMED   = 1'b0,
    TRIPPED = 1'b1
  } chan_state_e;

endpackage

// File: rtl/amp_safety_check_if.sv
// Sample bus, enables and clear strobes in; latched disables and live error flags out.
interface amp_safety_check_if #(
  parameter int unsigned CHAN_W   = 2,
  parameter int unsigned NUM_CHAN = 4
);
  import safety_pkg::*;

  logic                cur_valid;
  logic [CHAN_W-1:0]   cur_chan;
  logic [CUR_W-1:0]    cur_fb;
  logic [CUR_W-1:0]    cur_cmd;
  logic [NUM_CHAN-1:0] amp_enabled;
  logic [NUM_CHAN-1:0] clear_mask;
  logic [NUM_CHAN-1:0] safety_amp_disable;
  logic [NUM_CHAN-1:0] err_active;

  modport master (
    output cur_valid,
    output cur_chan,
    output cur_fb,
    output cur_cmd,
    output amp_enabled,
    output clear_mask,
    input  safety_amp_disable,
    input  err_active
  );

  modport slave (
    input  cur_valid,
    input  cur_chan,
    input  cur_fb,
    input  cur_cmd,
    input  amp_enabled,
    input  clear_mask,
    output safety_amp_disable,
    output err_active
  );

endinterface

// File: rtl/amp_safety_check_abs_diff16.sv
// Combinational |a - b| of two unsigned 16-bit codes, saturated to 16 bits.
module abs_diff16
  import safety_pkg::*;
(
  input  logic [CUR_W-1:0] a,
  input  logic [CUR_W-1:0] b,
  output logic [CUR_W-1:0] abs_diff
);

  logic signed [CUR_W:0]   diff;
  logic signed [CUR_W+1:0] mag;

  function automatic logic [CUR_W-1:0] sat_u16(input logic signed [CUR_W+1:0] v);
    if (v[CUR_W+1] || v[CUR_W]) return '1;
    return v[CUR_W-1:0];
  endfunction

  always_comb begin
    diff     = $signed({1'b0, a}) - $signed({1'b0, b});
    mag      = diff[CUR_W] ? -((CUR_W+2)'(diff)) : (CUR_W+2)'(diff);
    abs_diff = sat_u16(mag);
  end

endmodule

// File: rtl/amp_safety_check.sv
// Per-axis amplifier current monitor: counts consecutive over-threshold samples per
// channel and latches an amp-disable when the count reaches the limit.
module amp_safety_check #(
  parameter int unsigned NUM_CHAN   = 4,
  parameter logic [15:0] ERR_THRESH = 16'd2000,
  parameter logic [7:0]  ERR_LIMIT  = 8'd10
) (
  input  logic              sysclk,
  input  logic              reset,
  amp_safety_check_if.slave bus
);
  import safety_pkg::*;

  localparam int unsigned IDX_W = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  logic [CUR_W-1:0] abs_c;
  logic             chan_ok;

  abs_diff16 u_abs (
    .a        (bus.cur_fb),
    .b        (bus.cur_cmd),
    .abs_diff (abs_c)
  );

  assign chan_ok = 32'(bus.cur_chan) < NUM_CHAN;

  // ---- stage 1: magnitude and channel capture ----
  logic             vld_p1;
  logic [CUR_W-1:0] abs_p1;
  logic [IDX_W-1:0] chan_p1;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= bus.cur_valid & chan_ok;
  end

  always_ff @(posedge sysclk) begin
    if (bus.cur_valid) begin
      abs_p1  <= abs_c;
      chan_p1 <= bus.cur_chan[IDX_W-1:0];
    end
  end

  // ---- stage 2: per-channel counters and latches ----
  logic                over_p1;
  logic [NUM_CHAN-1:0] dis_vec;
  logic [NUM_CHAN-1:0] err_vec;

  assign over_p1 = abs_p1 > ERR_THRESH;

  for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
    chan_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             en;
    logic             smp;
    logic             hit;
    logic             trip;
    logic             clr;
    logic [CNT_W:0]   cnt_plus;

    assign en       = bus.amp_enabled[c];
    assign clr      = bus.clear_mask[c];
    assign smp      = vld_p1 && (chan_p1 == IDX_W'(c));
    assign hit      = smp && over_p1 && en;
    assign cnt_plus = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign trip     = hit && (cnt_plus >= {1'b0, ERR_LIMIT});

    // A disabled axis never accumulates; a trip outranks a simultaneous clear.
    always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
        state_q <= ARMED;
        cnt_q   <= '0;
        err_q   <= 1'b0;
      end else if (!en) begin
        cnt_q <= '0;
        err_q <= 1'b0;
        if (clr) state_q <= ARMED;
      end else if (trip) begin
        cnt_q   <= sat_inc(cnt_q);
        err_q   <= 1'b1;
        state_q <= TRIPPED;
      end else if (clr) begin
        cnt_q   <= '0;
        err_q   <= 1'b0;
        state_q <= ARMED;
      end else if (smp) begin
        if (hit) begin
          cnt_q <= sat_inc(cnt_q);
          err_q <= 1'b1;
        end else begin
          cnt_q <= '0;
          err_q <= 1'b0;
        end
      end
    end

    assign dis_vec[c] = (state_q == TRIPPED);
    assign err_vec[c] = err_q;
  end

  assign bus.safety_amp_disable = dis_vec;
  assign bus.err_active         = err_vec;

endmodule

// File: tb/tb_amp_safety_check.sv
// Bench for amp_safety_check: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a rule-level model.
module tb_amp_safety_check;
  import safety_pkg::*;

  localparam int THR = 2000;
  localparam int LIM = 10;
  localparam int Z   = 32768;

  logic sysclk = 1'b0;
  logic reset;

  amp_safety_check_if #(.CHAN_W(3), .NUM_CHAN(4)) bus ();

  amp_safety_check #(
    .NUM_CHAN   (4),
    .ERR_THRESH (16'd2000),
    .ERR_LIMIT  (8'd10)
  ) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus.slave)
  );

  always #10 sysclk = ~sysclk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Rule-level model: one in-flight sample, then the per-channel update rules.
  int m_cnt [4];
  bit m_err [4];
  bit m_lat [4];
  bit p_vld;
  int p_ch;
  int p_abs;

  always @(posedge sysclk or posedge reset) begin
    bit en, smp, over, trip, clr;
    if (reset) begin
      for (int c = 0; c < 4; c++) begin
        m_cnt[c] = 0; m_err[c] = 0; m_lat[c] = 0;
      end
      p_vld = 0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        en   = bus.amp_enabled[c];
        clr  = bus.clear_mask[c];
        smp  = p_vld && (p_ch == c);
        over = smp && (p_abs > THR);
        trip = en && over && (m_cnt[c] + 1 >= LIM);
        if (!en) begin
          m_cnt[c] = 0; m_err[c] = 0;
          if (clr) m_lat[c] = 0;
        end else if (trip) begin
          m_cnt[c] = (m_cnt[c] < 255) ? m_cnt[c] + 1 : 255;
          m_err[c] = 1; m_lat[c] = 1;
        end else if (clr) begin
          m_cnt[c] = 0; m_err[c] = 0; m_lat[c] = 0;
        end else if (smp) begin
          if (over) begin
            m_cnt[c] = (m_cnt[c] < 255) ? m_cnt[c] + 1 : 255;
            m_err[c] = 1;
          end else begin
            m_cnt[c] = 0; m_err[c] = 0;
          end
        end
      end
      p_vld = bus.cur_valid && (int'(bus.cur_chan) < 4);
      p_ch  = int'(bus.cur_chan);
      p_abs = int'(bus.cur_fb) - int'(bus.cur_cmd);
      if (p_abs < 0) p_abs = -p_abs;
      if (p_abs > 65535) p_abs = 65535;
    end
  end

  always @(negedge sysclk) begin
    logic [3:0] e_dis, e_err;
    for (int c = 0; c < 4; c++) begin
      e_dis[c] = m_lat[c];
      e_err[c] = m_err[c];
    end
    check("disable_vs_model", 32'(bus.safety_amp_disable), 32'(e_dis));
    check("err_active_vs_model", 32'(bus.err_active), 32'(e_err));
  end

  task automatic drive(input bit v, input int ch, input int fb, input int cmd,
                       input logic [3:0] clr = 4'b0000);
    bus.cur_valid  = v;
    bus.cur_chan   = 3'(ch);
    bus.cur_fb     = 16'(fb);
    bus.cur_cmd    = 16'(cmd);
    bus.clear_mask = clr;
    @(negedge sysclk);
    bus.cur_valid  = 1'b0;
    bus.clear_mask = 4'b0000;
  endtask

  task automatic idle(input int n = 1);
    repeat (n) drive(0, 0, Z, Z);
  endtask

  task automatic err_burst(input int ch, input int n);
    repeat (n) drive(1, ch, Z + 3000, Z);
  endtask

  task automatic pulse_reset();
    #5 reset = 1'b1;
    @(negedge sysclk);
    #5 reset = 1'b0;
    @(negedge sysclk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    reset           = 1'b1;
    bus.cur_valid   = 1'b0;
    bus.cur_chan    = 3'd0;
    bus.cur_fb      = CUR_ZERO;
    bus.cur_cmd     = CUR_ZERO;
    bus.amp_enabled = 4'hF;
    bus.clear_mask  = 4'h0;
    @(negedge sysclk);
    @(negedge sysclk);
    check("reset_disable", 32'(bus.safety_amp_disable), 32'h0);
    check("reset_err_active", 32'(bus.err_active), 32'h0);
    #5 reset = 1'b0;
    @(negedge sysclk);

    // Trip on ch 2 after exactly ten error samples.
    err_burst(2, 1);
    check("t1_err_before_stage2", 32'(bus.err_active), 32'h0);
    err_burst(2, 1);
    check("t1_err_first_sample", 32'(bus.err_active), 32'b0100);
    err_burst(2, 8);
    check("t1_no_early_trip", 32'(bus.safety_amp_disable), 32'h0);
    idle(1);
    check("t1_trip_ch2", 32'(bus.safety_amp_disable), 32'b0100);

    // Equal-to-threshold sample breaks the run on ch 0.
    pulse_reset();
    err_burst(0, 9);
    idle(1);
    check("t2_err_on", 32'(bus.err_active), 32'b0001);
    drive(1, 0, Z, Z + 2000);
    idle(1);
    check("t2_err_off_at_thresh", 32'(bus.err_active), 32'b0000);
    err_burst(0, 9);
    idle(1);
    check("t2_err_on_again", 32'(bus.err_active), 32'b0001);
    check("t2_no_trip", 32'(bus.safety_amp_disable), 32'h0);

    // Interleaved channels: only ch 3 is over threshold (negative difference).
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) drive(1, 1, Z + 100, Z);
      else            drive(1, 3, Z - 2500, Z);
    end
    check("t3_no_early_trip", 32'(bus.safety_amp_disable), 32'h0);
    idle(1);
    check("t3_trip_ch3", 32'(bus.safety_amp_disable), 32'b1000);
    err_burst(1, 9);
    idle(1);
    check("t3_ch1_count_zero", 32'(bus.safety_amp_disable), 32'b1000);

    // Clear colliding with a tripping update, then a lone clear.
    pulse_reset();
    err_burst(1, 10);
    drive(0, 0, Z, Z, 4'b0010);
    check("t4_trip_beats_clear", 32'(bus.safety_amp_disable), 32'b0010);
    check("t4_err_after_trip", 32'(bus.err_active), 32'b0010);
    drive(0, 0, Z, Z, 4'b0010);
    check("t4_lone_clear", 32'(bus.safety_amp_disable), 32'b0000);
    err_burst(1, 1);
    drive(0, 0, Z, Z, 4'b0010);
    check("t4_clear_beats_update", 32'(bus.err_active), 32'b0000);
    err_burst(1, 9);
    idle(1);
    check("t4_count_was_cleared", 32'(bus.safety_amp_disable), 32'b0000);
    err_burst(1, 1);
    idle(1);
    check("t4_retrip", 32'(bus.safety_amp_disable), 32'b0010);

    // Full-scale difference, disabled axis, and counter restart on re-enable.
    pulse_reset();
    bus.amp_enabled = 4'b1110;
    repeat (20) drive(1, 0, 16'hFFFF, 16'h0000);
    idle(1);
    check("t5_disabled_no_trip", 32'(bus.safety_amp_disable), 32'h0);
    check("t5_disabled_no_err", 32'(bus.err_active), 32'h0);
    bus.amp_enabled = 4'hF;
    repeat (10) drive(1, 0, 16'hFFFF, 16'h0000);
    idle(1);
    check("t5_fullscale_trip", 32'(bus.safety_amp_disable), 32'b0001);
    pulse_reset();
    err_burst(0, 5);
    idle(1);
    bus.amp_enabled = 4'b1110;
    idle(1);
    bus.amp_enabled = 4'hF;
    err_burst(0, 9);
    idle(1);
    check("t5_restart_no_trip", 32'(bus.safety_amp_disable), 32'h0);
    err_burst(0, 1);
    idle(1);
    check("t5_restart_trip", 32'(bus.safety_amp_disable), 32'b0001);

    // Reset between the stages of a tripping sample; out-of-range channel.
    pulse_reset();
    err_burst(2, 9);
    idle(1);
    err_burst(2, 1);
    pulse_reset();
    idle(1);
    check("t6_inflight_dropped_dis", 32'(bus.safety_amp_disable), 32'h0);
    check("t6_inflight_dropped_err", 32'(bus.err_active), 32'h0);
    err_burst(0, 9);
    idle(1);
    drive(1, 4, Z + 3000, Z);
    idle(1);
    check("t6_chan4_ignored_dis", 32'(bus.safety_amp_disable), 32'h0);
    check("t6_chan4_ignored_err", 32'(bus.err_active), 32'b0001);

    // Randomized traffic, checked every cycle by the model.
    pulse_reset();
    for (int i = 0; i < 600; i++) begin
      int kind, cmd, d, fb, ch;
      bit v;
      logic [3:0] clr;
      kind = $urandom_range(0, 5);
      cmd  = $urandom_range(0, 65535);
      case (kind)
        0:       d = $urandom_range(0, 1999);
        1:       d = 1999 + $urandom_range(0, 2);
        5:       d = $urandom_range(0, 65535);
        default: d = $urandom_range(2001, 8000);
      endcase
      fb = ($urandom_range(0, 1) == 1) ? cmd + d : cmd - d;
      if (fb > 65535 || fb < 0) fb = (fb > 65535) ? cmd - d : cmd + d;
      if (fb > 65535) fb = 65535;
      if (fb < 0) fb = 0;
      ch  = ($urandom_range(0, 15) == 0) ? 4 : $urandom_range(0, 3);
      v   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 30) == 0)
        bus.amp_enabled = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'hF;
      drive(v, ch, fb, cmd, clr);
      if (i % 200 == 199) pulse_reset();
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
